// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// The optional watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    // The arbiter only ever has one transaction in flight, so two states are enough.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Requester identifiers. These are the values used for grant_id and for last grant.
    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // Read data returned to a requester whose access was ended by the watchdog.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Width of the watchdog counter. This covers every TIMEOUT_CYCLES value up to 65535.
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin selector.
// When both requesters ask at once, the one that was not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic lastGrant_i,
    output logic reqAny_o,
    output logic grant_o
);

    // Choose the winner. A lone requester always wins. On a tie, grant the requester not served last.
    always_comb begin
        reqAny_o = valid0_i | valid1_i;
        grant_o  = GRANT_M0;
        if (valid0_i && valid1_i) begin
            grant_o = ~lastGrant_i;
        end else if (valid1_i) begin
            grant_o = GRANT_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two requesters (m0, m1) onto one shared memory port.
// Each transaction takes one IDLE cycle to arbitrate and then one or more BUSY cycles.
// During BUSY the owner's request is forwarded to the memory port.
// Defining MEM_ARB_TIMEOUT_EN compiles in a watchdog. The watchdog forces completion after
// TIMEOUT_CYCLES BUSY cycles and returns TIMEOUT_RDATA to the owner.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            m0_valid,
    input  logic            m0_insn,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_wstrb,
    output logic            m0_ready,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_valid,
    input  logic            m1_insn,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_wstrb,
    output logic            m1_ready,
    output logic [XLEN-1:0] m1_rdata,

    output logic            s_valid,
    output logic            s_insn,
    output logic [XLEN-1:0] s_addr,
    output logic [XLEN-1:0] s_wdata,
    output logic [3:0]      s_wstrb,
    input  logic            s_ready,
    input  logic [XLEN-1:0] s_rdata,

    output logic            grant_id,
    output logic            busy,
    output logic            timeout_err
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       lastGrant_q, lastGrant_d;

    logic       arbAny;
    logic       arbGrant;
    logic       ownerValid;
    logic       complete;
    logic       tmoHit;
    logic       tmoFire;

    rr_arb2 u_rr_arb2 (
        .valid0_i    (m0_valid),
        .valid1_i    (m1_valid),
        .lastGrant_i (lastGrant_q),
        .reqAny_o    (arbAny),
        .grant_o     (arbGrant)
    );

    assign ownerValid = (owner_q == GRANT_M1) ? m1_valid : m0_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [TMO_CNT_W-1:0] tmoCount_q, tmoCount_d;
    logic                 tmoErr_q;

    assign tmoHit = (tmoCount_q == TMO_LIMIT);

    // The count stays at zero outside BUSY, so every new transaction starts from zero.
    // It advances on each BUSY cycle that ends with the arbiter still in BUSY.
    always_comb begin
        tmoCount_d = '0;
        if ((state_q == ST_BUSY) && (state_d == ST_BUSY)) begin
            tmoCount_d = tmoCount_q + 1'b1;
        end
    end

    // Watchdog count register and sticky error flag. Only reset clears the flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmoCount_q <= '0;
            tmoErr_q   <= 1'b0;
        end else begin
            tmoCount_q <= tmoCount_d;
            tmoErr_q   <= tmoErr_q | tmoFire;
        end
    end

    assign timeout_err = tmoErr_q;
`else
    assign tmoHit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic.
    // IDLE latches the arbitration winner.
    // BUSY ends on an abandoned request, a memory completion, or a watchdog expiry.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        complete    = 1'b0;
        tmoFire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arbAny) begin
                    state_d = ST_BUSY;
                    owner_d = arbGrant;
                end
            end
            ST_BUSY: begin
                if (!ownerValid) begin
                    state_d = ST_IDLE;
                end else if (s_ready) begin
                    complete = 1'b1;
                end else if (tmoHit) begin
                    complete = 1'b1;
                    tmoFire  = 1'b1;
                end
                if (complete) begin
                    state_d     = ST_IDLE;
                    lastGrant_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and round-robin history registers.
    // Reset makes m0 the winner of the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= GRANT_M0;
            lastGrant_q <= GRANT_M1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Output logic.
    // In BUSY the owner's request is forwarded to the memory port and the completion is routed back to the owner.
    // Read data is shared by both requesters, except when the watchdog substitutes its marker value.
    always_comb begin
        s_valid  = 1'b0;
        s_insn   = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        if (state_q == ST_BUSY) begin
            s_valid = ownerValid;
            if (owner_q == GRANT_M1) begin
                s_insn  = m1_insn;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_insn  = m0_insn;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
            m0_ready = complete && (owner_q == GRANT_M0);
            m1_ready = complete && (owner_q == GRANT_M1);
        end
        if (tmoFire) begin
            if (owner_q == GRANT_M1) begin
                m1_rdata = XLEN'(TIMEOUT_RDATA);
            end else begin
                m0_rdata = XLEN'(TIMEOUT_RDATA);
            end
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// It runs directed scenarios first, then randomized traffic checked against a transaction-level reference model.
// When MEM_ARB_TIMEOUT_EN is defined, the watchdog scenario and the model's timeout rule are also active.
module tb_mem_bus_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic            mValid [2];
    logic            mInsn  [2];
    logic [XLEN-1:0] mAddr  [2];
    logic [XLEN-1:0] mWdata [2];
    logic [3:0]      mWstrb [2];
    logic            mReady [2];
    logic [XLEN-1:0] mRdata [2];

    logic            s_valid, s_insn, s_ready;
    logic [XLEN-1:0] s_addr, s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic            grant_id, busy, timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model: whether a transaction is in flight, whom it belongs to,
    // who was served last, how long it has waited, and whether a timeout has ever happened.
    bit mdlBusy;
    int mdlOwner;
    int mdlLast;
    int mdlWait;
    bit mdlErr;

    // Snapshot of the outputs from the most recent stepped cycle.
    logic            obsBusy, obsGrant;
    logic            obsReady [2];
    logic [XLEN-1:0] obsRdata [2];

    mem_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .m0_valid    (mValid[0]),
        .m0_insn     (mInsn[0]),
        .m0_addr     (mAddr[0]),
        .m0_wdata    (mWdata[0]),
        .m0_wstrb    (mWstrb[0]),
        .m0_ready    (mReady[0]),
        .m0_rdata    (mRdata[0]),
        .m1_valid    (mValid[1]),
        .m1_insn     (mInsn[1]),
        .m1_addr     (mAddr[1]),
        .m1_wdata    (mWdata[1]),
        .m1_wstrb    (mWstrb[1]),
        .m1_ready    (mReady[1]),
        .m1_rdata    (mRdata[1]),
        .s_valid     (s_valid),
        .s_insn      (s_insn),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Count one comparison, and report it if the observed and expected values differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Put a new request on requester n's address and data lines.
    task automatic setReq(input int n, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic insn);
        mAddr[n]  = addr;
        mWdata[n] = wdata;
        mWstrb[n] = wstrb;
        mInsn[n]  = insn;
    endtask

    // Reset the model to its power-on view: idle, and m0 wins the first tie.
    task automatic modelReset();
        mdlBusy  = 1'b0;
        mdlOwner = 0;
        mdlLast  = 1;
        mdlWait  = 0;
        mdlErr   = 1'b0;
    endtask

    // One clock cycle, starting and ending just after a rising edge.
    // Outputs are compared with the model on the falling edge, then the model advances.
    task automatic stepCycle();
        logic ownerValid;
        bit   done, expired;
        int   other;
        @(negedge clock);
        ownerValid = mValid[mdlOwner];
        expired    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        expired = mdlBusy && ownerValid && !s_ready && (mdlWait == TMO);
`endif
        done  = mdlBusy && ownerValid && (s_ready || expired);
        other = 1 - mdlOwner;
        checkOutput("busy", busy, mdlBusy);
        checkOutput("s_valid", s_valid, mdlBusy && ownerValid);
        if (mdlBusy) begin
            checkOutput("grant_id", grant_id, mdlOwner);
            checkOutput("s_addr", s_addr, mAddr[mdlOwner]);
            checkOutput("s_wdata", s_wdata, mWdata[mdlOwner]);
            checkOutput("s_wstrb", s_wstrb, mWstrb[mdlOwner]);
            checkOutput("s_insn", s_insn, mInsn[mdlOwner]);
        end
        checkOutput("owner_ready", mReady[mdlOwner], done);
        checkOutput("other_ready", mReady[other], 1'b0);
        checkOutput("owner_rdata", mRdata[mdlOwner], expired ? 32'hDEAD_BEEF : s_rdata);
        checkOutput("other_rdata", mRdata[other], s_rdata);
        checkOutput("timeout_err", timeout_err, mdlErr);
        obsBusy     = busy;
        obsGrant    = grant_id;
        obsReady[0] = mReady[0];
        obsReady[1] = mReady[1];
        obsRdata[0] = mRdata[0];
        obsRdata[1] = mRdata[1];
        if (!mdlBusy) begin
            if (mValid[0] || mValid[1]) begin
                mdlBusy  = 1'b1;
                mdlWait  = 0;
                mdlOwner = (mValid[0] && mValid[1]) ? (1 - mdlLast) : (mValid[0] ? 0 : 1);
            end
        end else if (!ownerValid) begin
            mdlBusy = 1'b0;
        end else if (done) begin
            mdlBusy = 1'b0;
            mdlLast = mdlOwner;
            if (expired) mdlErr = 1'b1;
        end else begin
            mdlWait++;
        end
        @(posedge clock);
        #1;
    endtask

    // Drive the valid lines and the memory response for one cycle, then step.
    task automatic applyStimulus(input logic v0, input logic v1, input logic sr, input logic [31:0] rd);
        mValid[0] = v0;
        mValid[1] = v1;
        s_ready   = sr;
        s_rdata   = rd;
        stepCycle();
    endtask

    // Assert reset between clock edges, check the reset outputs, and release it after the next rising edge.
    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_s_valid", s_valid, 1'b0);
        checkOutput("rst_grant", grant_id, 1'b0);
        checkOutput("rst_ready0", mReady[0], 1'b0);
        checkOutput("rst_ready1", mReady[1], 1'b0);
        checkOutput("rst_err", timeout_err, 1'b0);
        @(posedge clock);
        #1;
        mValid[0] = 1'b0;
        mValid[1] = 1'b0;
        s_ready   = 1'b0;
        reset     = 1'b0;
        modelReset();
    endtask

    initial begin
        int  busyCnt;
        bit  seen;
        for (int n = 0; n < 2; n++) begin
            mValid[n] = 1'b0;
            setReq(n, 32'h0, 32'h0, 4'h0, 1'b0);
        end
        s_ready = 1'b0;
        s_rdata = '0;
        modelReset();

        @(posedge clock);
        #1;
        doReset();

        // m0 reads 0x100 alone. Memory answers on the second BUSY cycle.
        setReq(0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("rd_idle_ready", obsReady[0], 1'b0);
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("rd_wait_ready", obsReady[0], 1'b0);
        applyStimulus(1, 0, 1, 32'h1122_3344);
        checkOutput("rd_ready0", obsReady[0], 1'b1);
        checkOutput("rd_rdata0", obsRdata[0], 32'h1122_3344);
        checkOutput("rd_ready1", obsReady[1], 1'b0);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("rd_single_pulse", obsReady[0], 1'b0);

        // m1 single-byte write. The memory port must carry m1's fields exactly.
        setReq(1, 32'h2000_0000, 32'h0000_0041, 4'b0001, 1'b0);
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("wr_s_valid", s_valid, 1'b1);
        checkOutput("wr_s_addr", s_addr, 32'h2000_0000);
        checkOutput("wr_s_wdata", s_wdata, 32'h0000_0041);
        checkOutput("wr_s_wstrb", s_wstrb, 4'b0001);
        applyStimulus(0, 1, 1, 32'h0);
        checkOutput("wr_ready1", obsReady[1], 1'b1);
        applyStimulus(0, 0, 0, 32'h0);

        // Reset arrives mid-transaction while memory is asserting s_ready. Nothing may complete.
        setReq(0, 32'h0000_0200, 32'h0, 4'h0, 1'b1);
        applyStimulus(1, 0, 0, 32'h0);
        s_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_s_valid", s_valid, 1'b0);
        checkOutput("mid_rst_ready0", mReady[0], 1'b0);
        checkOutput("mid_rst_ready1", mReady[1], 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        doReset();

        // Both requesters ask continuously from the first cycle after reset.
        // Expected: grants alternate 0,1,0,1,0,1, with a dead cycle between transactions.
        setReq(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0);
        setReq(1, 32'h0000_0400, 32'hA5, 4'hF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 1, 32'h600D_0000 + i);
            if (i % 2 == 0) begin
                checkOutput("rr_dead_cycle", obsBusy, 1'b0);
            end else begin
                checkOutput("rr_busy", obsBusy, 1'b1);
                checkOutput("rr_grant", obsGrant, (i / 2) % 2);
                checkOutput("rr_ready_owner", obsReady[(i / 2) % 2], 1'b1);
            end
        end
        applyStimulus(0, 0, 0, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers. The watchdog completes after TMO waiting BUSY cycles.
        doReset();
        setReq(0, 32'h0000_0500, 32'h0, 4'h0, 1'b0);
        busyCnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 4 * TMO && !seen; i++) begin
            applyStimulus(1, 0, 0, 32'h5555_5555);
            if (obsReady[0]) seen = 1'b1;
            else if (obsBusy) busyCnt++;
        end
        checkOutput("tmo_seen", seen, 1'b1);
        checkOutput("tmo_cycles", busyCnt, TMO);
        checkOutput("tmo_rdata", obsRdata[0], 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("tmo_err_sticky", timeout_err, 1'b1);
`else
        busyCnt = 0;
        seen    = 1'b0;
`endif

        // Randomized traffic. A requester holds its request until ready, then either goes quiet or issues a new one.
        // Occasionally a requester abandons its request.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (obsReady[n] || !mValid[n]) begin
                    mValid[n] = ($urandom % 3) == 0;
                    if (mValid[n]) setReq(n, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom % 2));
                end else if (($urandom % 40) == 0) begin
                    mValid[n] = 1'b0;
                end
            end
            s_ready = ($urandom % 3) == 0;
            s_rdata = $urandom;
            stepCycle();
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data/address width of all buses.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, BUSY cycles before forced completion; used only when the timeout feature is compiled in.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port mN_valid (N=0,1), input, 1, requester N transaction request; held until mN_ready.
REQ-006 The block SHALL have port mN_insn, input, 1, requester N instruction-fetch flag.
REQ-007 The block SHALL have port mN_addr, input, XLEN, requester N byte address.
REQ-008 The block SHALL have port mN_wdata, input, XLEN, requester N write data.
REQ-009 The block SHALL have port mN_wstrb, input, 4, requester N byte strobes; 0 means read.
REQ-010 The block SHALL have port mN_ready, output, 1, one-cycle completion pulse to requester N.
REQ-011 The block SHALL have port mN_rdata, output, XLEN, read data to requester N.
REQ-012 The block SHALL have port s_valid/s_insn/s_addr/s_wdata/s_wstrb, output, 1/1/XLEN/XLEN/4, shared memory request.
REQ-013 The block SHALL have port s_ready, input, 1, shared memory completion.
REQ-014 The block SHALL have port s_rdata, input, XLEN, shared memory read data.
REQ-015 The block SHALL have port grant_id, output, 1, current owner (valid when busy=1).
REQ-016 The block SHALL have port busy, output, 1, high in BUSY state.
REQ-017 The block SHALL have port timeout_err, output, 1, sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE and BUSY only.
REQ-019 In IDLE with exactly one mN_valid high, that requester SHALL be latched as owner and the FSM SHALL enter BUSY next edge.
REQ-020 In IDLE with both valid, the requester not equal to last_grant SHALL win (round-robin).
REQ-021 In IDLE, s_valid and both mN_ready SHALL be 0.
REQ-022 In BUSY, s_valid/s_insn/s_addr/s_wdata/s_wstrb SHALL combinationally follow the owner's inputs.
REQ-023 In BUSY, s_ready=1 SHALL produce owner mN_ready=1 in the same cycle; non-owner ready SHALL remain 0.
REQ-024 On that cycle, last_grant SHALL update to owner and the FSM SHALL return to IDLE, giving a minimum of one dead cycle between transactions.
REQ-025 mN_rdata SHALL equal s_rdata for both requesters at all times, except during a forced timeout completion (REQ-032).
REQ-026 If owner's valid drops in BUSY without s_ready, the FSM SHALL return to IDLE with no ready pulse and last_grant unchanged.
REQ-027 Requester-to-slave latency SHALL be exactly one cycle (request cycle in IDLE, forwarded cycle in BUSY).

Reset
REQ-028 On reset asserted, state SHALL be IDLE, last_grant SHALL be 1 (m0 wins first tie), grant_id SHALL be 0, busy SHALL be 0, timeout counter SHALL be 0 and timeout_err SHALL be 0, asynchronously.
REQ-029 Reset mid-transaction SHALL drop s_valid and all mN_ready immediately, without waiting for s_ready.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN SHALL gate the timeout watchdog.
REQ-031 When MEM_ARB_TIMEOUT_EN is defined, an 8..16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-032 When the counter equals TIMEOUT_CYCLES, owner mN_ready SHALL pulse with mN_rdata=TIMEOUT_RDATA (32'hDEAD_BEEF), timeout_err SHALL set (sticky until reset), and the FSM SHALL return to IDLE.
REQ-033 When MEM_ARB_TIMEOUT_EN is undefined, no counter SHALL exist, timeout_err SHALL tie to 0, and BUSY SHALL wait indefinitely.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum, grant id constants (GRANT_M0=0, GRANT_M1=1) and TIMEOUT_RDATA.
REQ-035 Sub-module rr_arb2 SHALL compute the winner from the two valids and last_grant, purely combinationally.

Verification
REQ-036 m0 reads 0x100 alone, memory returns 0x11223344 after 2 cycles -> m0_ready is one pulse with m0_rdata=0x11223344, m1_ready stays 0.
REQ-037 Both valid in the first cycle after reset -> m0 is served first, then m1, with one dead cycle between them; grant_id is 0 then 1.
REQ-038 Both valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-039 m1 write 0x2000_0000, wstrb=4'b0001, wdata=0x41 -> s_addr/s_wdata/s_wstrb match m1 exactly during BUSY.
REQ-040 Reset pulse during BUSY before s_ready -> s_valid=0 in the same cycle, with no ready pulse on either requester.
REQ-041 With MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and s_ready never asserted -> owner ready after 8 BUSY cycles, rdata=0xDEADBEEF, timeout_err=1.
